// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified instruction/data memory port:
// arbiter state encoding, requester ownership and byte-enable width helper.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    function automatic int be_width(input int size);
        return size / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Command/response bus between the arbiter (master) and the unified memory (slave).
interface mem_port_arbiter_if #(
    parameter int SIZE = 32,
    parameter int BE_W = riscv_mem_pkg::be_width(SIZE)
);
    logic            mem_req;
    logic            mem_we;
    logic [SIZE-1:0] mem_addr;
    logic [SIZE-1:0] mem_wdata;
    logic [BE_W-1:0] mem_be;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [SIZE-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store, one transaction
// at a time; data has fixed priority and flushed fetch responses are discarded.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int BE_W = be_width(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [SIZE-1:0]   if_addr,
    output logic [SIZE-1:0]   if_rdata,
    output logic              if_valid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [SIZE-1:0]   d_addr,
    input  logic [SIZE-1:0]   d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic [SIZE-1:0]   d_rdata,
    output logic              d_valid,

    input  logic              flush_if,

    mem_port_arbiter_if.master mem,

    output logic              stallf,
    output logic              stallM
);

    arb_state_t state_reg;
    logic       owner_reg;
    logic       drop_reg;

    // A flush arriving together with the response must still kill it.
    logic kill_fetch;
    assign kill_fetch = drop_reg | flush_if;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_IF;
            drop_reg      <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            if_valid      <= 1'b0;
            d_valid       <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (d_req) begin
                        mem.mem_we    <= d_we;
                        mem.mem_addr  <= d_addr;
                        mem.mem_wdata <= d_wdata;
                        mem.mem_be    <= d_be;
                        mem.mem_req   <= 1'b1;
                        owner_reg     <= OWN_D;
                        state_reg     <= REQ;
                    end else if (if_req) begin
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= if_addr;
                        mem.mem_wdata <= '0;
                        mem.mem_be    <= '1;
                        mem.mem_req   <= 1'b1;
                        owner_reg     <= OWN_IF;
                        state_reg     <= REQ;
                    end
                end
                REQ: begin
                    if (owner_reg == OWN_IF && flush_if)
                        drop_reg <= 1'b1;
                    // A response in the acceptance cycle is not legal and is ignored.
                    if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        state_reg   <= RESP;
                    end
                end
                RESP: begin
                    if (owner_reg == OWN_IF && flush_if)
                        drop_reg <= 1'b1;
                    if (mem.mem_rvalid) begin
                        if (owner_reg == OWN_D) begin
                            d_rdata <= mem.mem_rdata;
                            d_valid <= 1'b1;
                        end else if (!kill_fetch) begin
                            if_rdata <= mem.mem_rdata;
                            if_valid <= 1'b1;
                        end
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not sampled here, so a still-held req is not re-issued.
                    drop_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stallf = if_req & ~if_valid;
    assign stallM = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory with programmable wait states,
// a vector table scored through an expected-result queue, and corner-case sequences.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        flush_if = 1'b0;
    logic        stallf;
    logic        stallM;

    mem_port_arbiter_if #(.SIZE(32)) bus ();

    mem_port_arbiter #(.SIZE(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .flush_if (flush_if),
        .mem      (bus),
        .stallf   (stallf),
        .stallM   (stallM)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_wait = 0;
    int rvalid_wait = 0;
    logic [31:0] last_fetch = '0;
    logic [31:0] mem_model [logic [31:0]];

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          rw;
        int          vw;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        check_data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a >> 2)) return mem_model[a >> 2];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Memory: accepts after ready_wait cycles, responds rvalid_wait cycles after acceptance.
    initial begin : responder
        logic        started;
        logic        pending;
        int          wcnt;
        int          rcnt;
        logic [31:0] a0;
        logic [31:0] wd0;
        logic        we0;
        logic [3:0]  be0;
        started = 0; pending = 0; wcnt = 0; rcnt = 0;
        a0 = '0; wd0 = '0; we0 = 0; be0 = '0;
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        forever begin
            tick();
            if (!rst_n) begin
                started = 0; pending = 0;
                bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 0;
                if (we0) mem_model[a0 >> 2] = merge(model_read(a0), wd0, be0);
                rcnt = rvalid_wait;
                if (rcnt == 0) begin
                    bus.mem_rvalid = 1;
                    bus.mem_rdata  = we0 ? 32'h0 : model_read(a0);
                end else begin
                    pending = 1;
                end
            end else if (bus.mem_rvalid) begin
                bus.mem_rvalid = 0;
                bus.mem_rdata  = '0;
            end else if (pending) begin
                rcnt--;
                if (rcnt == 0) begin
                    pending = 0;
                    bus.mem_rvalid = 1;
                    bus.mem_rdata  = we0 ? 32'h0 : model_read(a0);
                end
            end else if (bus.mem_req) begin
                if (!started) begin
                    started = 1;
                    wcnt = ready_wait;
                    a0 = bus.mem_addr; wd0 = bus.mem_wdata; we0 = bus.mem_we; be0 = bus.mem_be;
                end else begin
                    chk("hold_addr", bus.mem_addr, a0);
                    chk("hold_wdata", bus.mem_wdata, wd0);
                    chk("hold_we", bus.mem_we, we0);
                    chk("hold_be", bus.mem_be, be0);
                end
                if (wcnt == 0) begin
                    bus.mem_ready = 1;
                    started = 0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic seen;
        ready_wait  = v.rw;
        rvalid_wait = v.vw;
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        e.is_d = v.is_d; e.rdata = v.exp_rdata; e.check_data = !(v.is_d && v.we); e.lat = v.exp_lat;
        sb.push_back(e);
        #1;
        chk("stall_c0", v.is_d ? stallM : stallf, 1);
        seen = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            tick();
            if (n == 1) begin
                chk("mem_req_c1", bus.mem_req, 1);
                chk("mem_addr_c1", bus.mem_addr, v.addr);
                chk("mem_we_c1", bus.mem_we, v.is_d & v.we);
                chk("mem_be_c1", bus.mem_be, v.is_d ? v.be : 4'hF);
            end
            if (if_valid || d_valid) begin
                seen = 1;
                e = sb.pop_front();
                chk("valid_pair", {if_valid, d_valid}, e.is_d ? 2'b01 : 2'b10);
                chk("latency", n, e.lat);
                if (e.check_data) chk("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                chk("stall_done", e.is_d ? stallM : stallf, 0);
                if (!e.is_d) last_fetch = e.rdata;
                $display("txn %s addr=%h lat=%0d", e.is_d ? "D " : "IF", v.addr, n);
                if_req = 0; d_req = 0;
            end
        end
        chk("valid_seen", seen, 1);
        if (!seen) begin
            if_req = 0; d_req = 0; sb.delete();
        end
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        vec_t v;
        int dcyc, icyc;
        logic any_valid;

        mem_model[32'h100 >> 2] = 32'h00500093;
        mem_model[32'h104 >> 2] = 32'h00A00113;
        mem_model[32'h10C >> 2] = 32'h00208233;
        mem_model[32'h110 >> 2] = 32'h00100193;
        mem_model[32'h200 >> 2] = 32'h12345678;
        mem_model[32'h044 >> 2] = 32'h11111111;

        //          is_d we  addr      wdata         be   rw vw exp_rdata     lat
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 0, 0, 32'h00500093, 3};
        vecs[1] = '{1'b1, 1'b1, 32'h040, 32'hDEADBEEF, 4'hF, 2, 1, 32'h0,        6};
        vecs[2] = '{1'b1, 1'b0, 32'h040, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 3};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'hF, 1, 2, 32'h12345678, 6};
        vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,        4'hF, 0, 3, 32'h00A00113, 6};
        vecs[5] = '{1'b1, 1'b1, 32'h044, 32'hCAFEF00D, 4'h3, 0, 0, 32'h0,        3};
        vecs[6] = '{1'b1, 1'b0, 32'h044, 32'h0,        4'hF, 0, 0, 32'h1111F00D, 3};

        #12;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_stalls", {stallf, stallM}, 0);
        tick();
        rst_n = 1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous fetch and load: data first, fetch re-granted after DONE.
        ready_wait = 0; rvalid_wait = 0;
        if_req = 1; if_addr = 32'h110;
        d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF;
        dcyc = -1; icyc = -1;
        for (int n = 1; n <= 30 && (dcyc < 0 || icyc < 0); n++) begin
            tick();
            if (n == 3) chk("sim_stallf_c3", stallf, 1);
            if (d_valid) begin
                dcyc = n; d_req = 0;
                chk("sim_d_rdata", d_rdata, 32'h12345678);
            end
            if (if_valid) begin
                icyc = n; if_req = 0;
                chk("sim_if_rdata", if_rdata, 32'h00100193);
                last_fetch = 32'h00100193;
            end
        end
        chk("sim_d_cycle", dcyc, 3);
        chk("sim_if_cycle", icyc, 7);
        $display("txn SIM d_cycle=%0d if_cycle=%0d", dcyc, icyc);
        if_req = 0; d_req = 0;
        tick();

        // Branch flush: in RESP with a late response, and together with the response.
        for (int fc = 0; fc < 2; fc++) begin
            ready_wait = 0; rvalid_wait = (fc == 0) ? 2 : 0;
            if_req = 1; if_addr = 32'h120 + 32'(fc * 4);
            tick();
            tick();
            flush_if = 1; if_req = 0;
            any_valid = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (k == 0) flush_if = 0;
                any_valid = any_valid | if_valid | d_valid;
            end
            chk("flush_no_valid", any_valid, 0);
            chk("flush_if_rdata", if_rdata, last_fetch);
            chk("flush_idle", bus.mem_req, 0);
            $display("txn FLUSH case=%0d valid=%0b", fc, any_valid);
        end
        v = '{1'b0, 1'b0, 32'h10C, 32'h0, 4'hF, 0, 0, 32'h00208233, 3};
        run_vec(v);

        // Reset in the middle of a stalled request.
        ready_wait = 5; rvalid_wait = 0;
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h55AA55AA; d_be = 4'hF;
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("mrst_mem_req", bus.mem_req, 0);
        chk("mrst_mem_we", bus.mem_we, 0);
        chk("mrst_mem_addr", bus.mem_addr, 0);
        chk("mrst_mem_wdata", bus.mem_wdata, 0);
        chk("mrst_mem_be", bus.mem_be, 0);
        chk("mrst_rdata", {if_rdata, d_rdata} == 64'h0, 1);
        chk("mrst_valids", {if_valid, d_valid}, 0);
        $display("txn RESET mem_req=%0b", bus.mem_req);
        d_req = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        v = '{1'b1, 1'b0, 32'h040, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF, 3};
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store) of the pipelined RISC-V core. It runs one transaction at a time with a request/accept/response handshake toward memory. Data requests win over fetch requests. It produces `stallf`/`stallM` for the hazard logic and drops fetch responses that a taken branch (`pc_sel`) has made stale.

## Interface
- `SIZE`, 32: address and data width.
- `BE_W`, `SIZE/8`: byte-enable width.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held high until `if_valid`.
- `if_addr`  in  SIZE  fetch address.
- `if_rdata`  out  SIZE  fetched instruction, registered.
- `if_valid`  out  1  one-cycle pulse; `if_rdata` is valid.
- `d_req`  in  1  load/store request; held high until `d_valid`.
- `d_we`  in  1  1 = store.
- `d_addr`  in  SIZE  data address.
- `d_wdata`  in  SIZE  store data.
- `d_be`  in  BE_W  byte enables.
- `d_rdata`  out  SIZE  load data, registered.
- `d_valid`  out  1  one-cycle pulse on load data or store acknowledge.
- `flush_if`  in  1  taken branch (`pc_sel`); kills the in-flight fetch.
- `mem_req`  out  1  command valid toward memory.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/SIZE/SIZE/BE_W  registered command fields.
- `mem_ready`  in  1  memory accepts the command.
- `mem_rvalid`  in  1  response valid (read data or write ack).
- `mem_rdata`  in  SIZE  read data.
- `stallf`  out  1  fetch stall.
- `stallM`  out  1  memory-stage stall.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. A 1-bit `owner` register records the granted requester (0 = IF, 1 = D).
- **IDLE:**
  - `d_req` high: latch the d_* fields into the command registers, set owner = D, go to REQ.
  - else `if_req` high: latch `if_addr`, set `mem_we`=0 and `mem_be`=all ones, owner = IF, go to REQ.
  - Data has fixed priority. This cannot starve fetch, because the MEM-stage instruction retires after its access.
- **REQ:** `mem_req` is high and the command fields are stable. `mem_req` must not drop and the fields must not change until `mem_ready`. On `mem_ready`, go to RESP.
- **RESP:** wait for `mem_rvalid`. On `mem_rvalid`, capture `mem_rdata` into the owner's rdata register and go to DONE.
- **DONE:** pulse `if_valid` or `d_valid` (by owner) for exactly one cycle. Requests are ignored in DONE, which prevents re-issue while the requester still holds `req`. Next state is IDLE.
- **Flush:**
  - `flush_if` while owner = IF in REQ or RESP sets the `drop` flag. The transaction still completes on the memory side.
  - In DONE with `drop` set, `if_valid` stays 0 and `if_rdata` is not updated. `drop` clears on leaving DONE.
  - `flush_if` in IDLE or DONE, or while owner = D, has no effect.
- **Stalls (combinational):**
  - `stallf = if_req & ~if_valid`
  - `stallM = d_req & ~d_valid`
- **Simultaneous events:**
  - `mem_ready` and `mem_rvalid` in the same cycle while in REQ: `mem_rvalid` is ignored. Memory must respond no earlier than the cycle after acceptance.
  - `flush_if` in the same cycle as `mem_rvalid` (owner = IF): the response is dropped.
- **Reset (including mid-transaction):**
  - State goes to IDLE; `owner`=0, `drop`=0.
  - `mem_req`, `mem_we`, `if_valid`, `d_valid` go to 0; `mem_addr`, `mem_wdata`, `mem_be`, `if_rdata`, `d_rdata` go to 0.
  - The memory model is reset by the same `rst_n`, so no orphan response is expected.

## Timing
- Request sampled in IDLE at cycle 0 → `mem_req` high at cycle 1.
- Zero-wait memory (`mem_ready` at 1, `mem_rvalid` at 2) → `*_valid` pulse at cycle 3. This is the minimum 3-cycle latency; the next grant can be made at cycle 4.
- Each `mem_ready` wait cycle and each `mem_rvalid` wait cycle adds exactly one cycle of latency.
- All outputs except `stallf`/`stallM` are registered.

## Structure
- Shared package `riscv_mem_pkg`: state enum (IDLE/REQ/RESP/DONE), owner encoding (`OWN_IF`=0, `OWN_D`=1), `BE_W` derivation.
- Single flat module. No sub-module is warranted: command mux, FSM and response registers all share the owner/state decode.

## Test plan
- **Lone fetch:** `if_req`=1, `if_addr`=0x100, memory returns 0x00500093 with zero wait → `mem_req` at cycle 1; `if_valid`=1 and `if_rdata`=0x00500093 at cycle 3; `stallf`=1 for cycles 0–2, 0 at cycle 3.
- **Simultaneous requests:** `if_req` and `d_req` (load, 0x200) both high at cycle 0 → data issued first, `d_valid` at 3; fetch sampled at cycle 4, `mem_req` at 5, `if_valid` at 7.
- **Store with wait states:** `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF, `d_be`=0xF; `mem_ready` delayed 2 cycles, `mem_rvalid` delayed 1 → `mem_req` held high with stable fields for 3 cycles; `d_valid` at cycle 6.
- **Branch flush:** fetch outstanding in RESP, `flush_if` pulse, memory responds → `if_valid` never asserts, `if_rdata` unchanged; the next fetch completes normally.
- **Reset mid-transaction:** `rst_n` low during REQ → within the same cycle (asynchronous) all outputs are 0 and the state is IDLE; after release, a new `d_req` completes with minimum latency.
